sw_arbiter: RTL and testbench

SW_ARBITER -- requirements
Module: sw_arbiter

---
 rtl/sw_arbiter.sv | 124 ++++++++++++
 tb/tb_sw_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sw_arbiter.sv
// Per-channel arbiter between physical switches and UART toggle commands.
// Define SW_DEBOUNCE_EN to build the per-channel debounce counters; otherwise the synchronized input is used directly.
module sw_arbiter #(
  parameter int          NUM_SW      = 4,
  parameter logic [7:0]  CMD_BASE    = 8'h61,
  parameter logic [7:0]  CMD_RELEASE = 8'h72,
  parameter int          DB_CYCLES   = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic [NUM_SW-1:0] sw_phy,
  output logic [NUM_SW-1:0] sw_final,
  output logic [NUM_SW-1:0] sw_own,
  output logic [NUM_SW-1:0] sw_change
);

  typedef enum logic {ST_PHY = 1'b0, ST_UART = 1'b1} own_state_e;

  if (NUM_SW < 1 || NUM_SW > 8 || DB_CYCLES < 2) begin : g_bad_param
    $error("sw_arbiter: illegal NUM_SW or DB_CYCLES");
  end

  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [NUM_SW-1:0] stable_q, stable_d;
  logic [NUM_SW-1:0] uart_q, uart_d;
  logic [NUM_SW-1:0] final_dly_q, change_q;
  own_state_e        state_q [NUM_SW];
  own_state_e        state_d [NUM_SW];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_phy;
      sync2_q <= sync1_q;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int             CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q [NUM_SW];
  logic [CW-1:0] cnt_d [NUM_SW];

  // Counter holds the number of prior consecutive differing cycles; it stops at DB_LAST.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] >= DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SW; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end
`else
  always_comb begin
    stable_d = sync2_q;
  end
`endif

  // A debounced physical edge wins over release and toggle commands.
  always_comb begin
    for (int i = 0; i < NUM_SW; i++) begin
      state_d[i] = state_q[i];
      uart_d[i]  = uart_q[i];
      if (stable_d[i] != stable_q[i]) begin
        state_d[i] = ST_PHY;
        uart_d[i]  = stable_d[i];
      end else if (rx_done && rx_data == CMD_RELEASE) begin
        state_d[i] = ST_PHY;
      end else if (rx_done && rx_data == (CMD_BASE + 8'(i))) begin
        if (state_q[i] == ST_PHY) begin
          uart_d[i]  = ~stable_q[i];
          state_d[i] = ST_UART;
        end else begin
          uart_d[i]  = ~uart_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q    <= '0;
      uart_q      <= '0;
      final_dly_q <= '0;
      change_q    <= '0;
    end else begin
      stable_q    <= stable_d;
      uart_q      <= uart_d;
      final_dly_q <= sw_final;
      change_q    <= sw_final ^ final_dly_q;
    end
    for (int i = 0; i < NUM_SW; i++) begin
      if (rst) state_q[i] <= ST_PHY;
      else     state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SW; i++) begin
      sw_own[i] = (state_q[i] == ST_UART);
    end
  end

  assign sw_final  = (sw_own & uart_q) | (~sw_own & stable_q);
  assign sw_change = change_q;

endmodule

// File: tb/tb_sw_arbiter.sv
// Directed bench for sw_arbiter (NUM_SW=4, DB_CYCLES=4); physical-path latency follows SW_DEBOUNCE_EN.
module tb_sw_arbiter;

  localparam int NUM_SW    = 4;
  localparam int DB_CYCLES = 4;
`ifdef SW_DEBOUNCE_EN
  localparam int LAT = 2 + DB_CYCLES;
`else
  localparam int LAT = 3;
`endif

  logic              clk;
  logic              rst;
  logic              rx_done;
  logic [7:0]        rx_data;
  logic [NUM_SW-1:0] sw_phy;
  logic [NUM_SW-1:0] sw_final;
  logic [NUM_SW-1:0] sw_own;
  logic [NUM_SW-1:0] sw_change;

  int n_checks = 0;
  int n_pass   = 0;

  sw_arbiter #(
    .NUM_SW      (NUM_SW),
    .CMD_BASE    (8'h61),
    .CMD_RELEASE (8'h72),
    .DB_CYCLES   (DB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .sw_phy    (sw_phy),
    .sw_final  (sw_final),
    .sw_own    (sw_own),
    .sw_change (sw_change)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  task automatic check(input string tag, input logic [NUM_SW-1:0] obs, input logic [NUM_SW-1:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %b expected %b", tag, obs, exp);
    else             n_pass++;
  endtask

  initial begin
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    sw_phy  = '0;
    tick(3);
    check("rst_final",  sw_final,  4'b0000);
    check("rst_own",    sw_own,    4'b0000);
    check("rst_change", sw_change, 4'b0000);
    rst = 1'b0;
    tick(2);

    // 'b' takes channel 1, inverting its debounced 0
    send_cmd(8'h62);
    check("b_final",   sw_final,  4'b0010);
    check("b_own",     sw_own,    4'b0010);
    check("b_chg_lo",  sw_change, 4'b0000);
    tick(1);
    check("b_chg_hi",  sw_change, 4'b0010);
    tick(1);
    check("b_chg_end", sw_change, 4'b0000);

    // three-cycle glitch on channel 1
    sw_phy = 4'b0010;
    tick(3);
    sw_phy = 4'b0000;
    tick(LAT + 2);
`ifdef SW_DEBOUNCE_EN
    check("glitch_final", sw_final,  4'b0010);
    check("glitch_own",   sw_own,    4'b0010);
    check("glitch_chg",   sw_change, 4'b0000);
`else
    check("glitch_final", sw_final, 4'b0000);
    check("glitch_own",   sw_own,   4'b0000);
    send_cmd(8'h62);
    check("reown_final",  sw_final, 4'b0010);
    check("reown_own",    sw_own,   4'b0010);
    tick(2);
`endif

    // toggle channel 1 back to 0, then a held physical high reclaims it
    send_cmd(8'h62);
    check("b2_final", sw_final, 4'b0000);
    check("b2_own",   sw_own,   4'b0010);
    tick(2);
    sw_phy = 4'b0010;
    tick(LAT - 1);
    check("hold_pre_own",   sw_own,   4'b0010);
    check("hold_pre_final", sw_final, 4'b0000);
    tick(1);
    check("hold_own",   sw_own,    4'b0000);
    check("hold_final", sw_final,  4'b0010);
    tick(1);
    check("hold_chg",   sw_change, 4'b0010);
    tick(2);

    // 'a', 'c', then release
    send_cmd(8'h61);
    check("a_own",   sw_own,   4'b0001);
    check("a_final", sw_final, 4'b0011);
    send_cmd(8'h63);
    check("c_own",   sw_own,   4'b0101);
    check("c_final", sw_final, 4'b0111);
    send_cmd(8'h72);
    check("r_own",   sw_own,    4'b0000);
    check("r_final", sw_final,  4'b0010);
    check("r_chg_c", sw_change, 4'b0100);
    tick(1);
    check("r_chg",   sw_change, 4'b0101);
    tick(2);

    // 'a' arrives on the very edge where channel 0 debounces high
    sw_phy = 4'b0011;
    tick(LAT - 1);
    send_cmd(8'h61);
    check("coll_own",   sw_own,   4'b0000);
    check("coll_final", sw_final, 4'b0011);
    tick(1);
    check("coll_own2",  sw_own,   4'b0000);

    // unknown code and strobe-less data are ignored
    send_cmd(8'h64);
    check("d_own",   sw_own,   4'b1000);
    check("d_final", sw_final, 4'b1011);
    send_cmd(8'h7a);
    check("z_own",   sw_own,   4'b1000);
    check("z_final", sw_final, 4'b1011);
    rx_data = 8'h61;
    tick(1);
    check("nostb_a_own",   sw_own,   4'b1000);
    check("nostb_a_final", sw_final, 4'b1011);
    rx_data = 8'h72;
    tick(1);
    check("nostb_r_own", sw_own, 4'b1000);

    // reset during a debounce, with a same-cycle 'd' strobe and physical change
    sw_phy = 4'b0000;
    tick(3);
    rst     = 1'b1;
    rx_data = 8'h64;
    rx_done = 1'b1;
    sw_phy  = 4'b1111;
    tick(1);
    check("mrst_final",  sw_final,  4'b0000);
    check("mrst_own",    sw_own,    4'b0000);
    check("mrst_change", sw_change, 4'b0000);
    tick(1);
    check("mrst_hold_final", sw_final, 4'b0000);
    check("mrst_hold_own",   sw_own,   4'b0000);
    rst     = 1'b0;
    rx_done = 1'b0;
    sw_phy  = 4'b0000;
    tick(LAT + 3);
    check("post_final",  sw_final,  4'b0000);
    check("post_own",    sw_own,    4'b0000);
    check("post_change", sw_change, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
